fb_span_writer: RTL and testbench

Framebuffer span writer: accepts horizontal-span draw requests (row, start column, end column, colour index) over a valid/ready handshake and emits single-port write strobes into the framebuffer's write port of the simple dual-port BRAM. It is the write-side counterpart to the framebuffer-to-linebuffer read path. Writes are issued only while `draw_en` is high (driven by the top level from the blanking interval), so the display-side reader never sees a partially drawn span mid-line. Clipping and rejection of off-screen requests happen here, so drawing logic upstream needs no bounds knowledge.

---
 rtl/fb_span_writer.sv | 125 ++++++++++++
 tb/tb_fb_span_writer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_span_writer.sv
// Framebuffer span writer.
// Takes horizontal span requests (row, first column, last column, colour),
// clips them to the framebuffer, rejects off-screen ones, and issues one
// framebuffer write per cycle while draw_en permits it.
module fb_span_writer #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int FB_DATAW  = 4,
  parameter int CORDW     = 16,
  parameter int FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                clk_pix,
  input  logic                rst,
  input  logic                draw_en,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CORDW-1:0]    req_y,
  input  logic [CORDW-1:0]    req_x0,
  input  logic [CORDW-1:0]    req_x1,
  input  logic [FB_DATAW-1:0] req_cidx,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                fb_we,
  output logic [FB_ADDRW-1:0] fb_addr_write,
  output logic [FB_DATAW-1:0] fb_cidx_write
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CORDW-1:0] WIDTH_C  = CORDW'(FB_WIDTH);
  localparam logic [CORDW-1:0] HEIGHT_C = CORDW'(FB_HEIGHT);
  localparam logic [CORDW-1:0] XMAX_C   = CORDW'(FB_WIDTH - 1);
  localparam logic [CORDW-1:0] ONE_C    = CORDW'(1);
  localparam logic [FB_ADDRW-1:0] ADDR_ONE_C = FB_ADDRW'(1);

  logic [1:0]          state;
  logic [CORDW-1:0]    span_y;
  logic [CORDW-1:0]    span_x0;
  logic [CORDW-1:0]    span_x1;
  logic [FB_DATAW-1:0] span_cidx;
  logic [CORDW-1:0]    remaining;
  logic [FB_ADDRW-1:0] addr;
  logic                reject;
  logic [CORDW-1:0]    x1c;
  logic [2*CORDW-1:0]  lin_addr;

  // Ready is decoded from state and held low while reset is asserted.
  assign req_ready = (state == S_IDLE) && !rst;

  // Clamp the last column to the right edge and form the full-width linear address.
  always_comb begin
    x1c      = (span_x1 > XMAX_C) ? XMAX_C : span_x1;
    lin_addr = (2*CORDW)'(span_y) * (2*CORDW)'(FB_WIDTH) + (2*CORDW)'(span_x0);
  end

  // Span FSM; a rejected span enters DRAW with nothing remaining, so both paths
  // share the single "remaining == 0" exit that raises done one cycle later.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      fb_we         <= 1'b0;
      fb_addr_write <= '0;
      fb_cidx_write <= '0;
      span_y        <= '0;
      span_x0       <= '0;
      span_x1       <= '0;
      span_cidx     <= '0;
      remaining     <= '0;
      addr          <= '0;
      reject        <= 1'b0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      fb_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            span_y    <= req_y;
            span_x0   <= req_x0;
            span_x1   <= req_x1;
            span_cidx <= req_cidx;
            busy      <= 1'b1;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          state <= S_DRAW;
          if (span_y >= HEIGHT_C || span_x0 >= WIDTH_C || span_x0 > x1c) begin
            reject    <= 1'b1;
            remaining <= '0;
          end else begin
            reject    <= 1'b0;
            addr      <= FB_ADDRW'(lin_addr);
            remaining <= x1c - span_x0 + ONE_C;
          end
        end
        S_DRAW: begin
          if (remaining == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= reject;
          end else if (draw_en) begin
            fb_we         <= 1'b1;
            fb_addr_write <= addr;
            fb_cidx_write <= span_cidx;
            addr          <= addr + ADDR_ONE_C;
            remaining     <= remaining - ONE_C;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_span_writer.sv
// Testbench for fb_span_writer: directed spans checked against a span-level
// model of expected writes and completion status, plus hand-computed timing.
module tb_fb_span_writer;

  localparam int FBW = 160;
  localparam int FBH = 120;

  logic        clk_pix = 1'b0;
  logic        rst = 1'b1;
  logic        draw_en = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_y = '0;
  logic [15:0] req_x0 = '0;
  logic [15:0] req_x1 = '0;
  logic [3:0]  req_cidx = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic        fb_we;
  logic [14:0] fb_addr_write;
  logic [3:0]  fb_cidx_write;

  fb_span_writer dut (
    .clk_pix(clk_pix), .rst(rst), .draw_en(draw_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_y(req_y), .req_x0(req_x0), .req_x1(req_x1), .req_cidx(req_cidx),
    .busy(busy), .done(done), .err(err),
    .fb_we(fb_we), .fb_addr_write(fb_addr_write), .fb_cidx_write(fb_cidx_write)
  );

  always #5 clk_pix = ~clk_pix;

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;
  int hsCyc = 0;
  int spanWrites = 0;
  int writesSeen = 0;
  bit checkEn = 1'b0;
  logic prevDrawEn = 1'b0;

  int expAddrQ[$];
  int expDataQ[$];
  int expCntQ[$];
  bit expErrQ[$];

  // Free-running cycle count and the draw_en value seen at each edge.
  always @(posedge clk_pix) begin
    cyc        <= cyc + 1;
    prevDrawEn <= draw_en;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCnt++;
    if (actual == expected) passCnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Model: every on-screen pixel of the clipped span, in column order.
  function automatic void pushSpan(input int y, input int x0, input int x1, input int c);
    int last;
    last = (x1 > FBW - 1) ? FBW - 1 : x1;
    if (y >= FBH || x0 >= FBW || x0 > last) begin
      expErrQ.push_back(1'b1);
      expCntQ.push_back(0);
    end else begin
      for (int x = x0; x <= last; x++) begin
        expAddrQ.push_back(y * FBW + x);
        expDataQ.push_back(c);
      end
      expErrQ.push_back(1'b0);
      expCntQ.push_back(last - x0 + 1);
    end
  endfunction

  // Compare process: every write and every done pulse against the model.
  always @(negedge clk_pix) begin
    if (checkEn && !rst) begin
      checkOutput("busy_vs_ready", int'(busy ^ req_ready), 1);
      if (fb_we) begin
        checkOutput("we_needs_draw_en", int'(prevDrawEn), 1);
        if (expAddrQ.size() == 0) checkOutput("unexpected_write", 1, 0);
        else begin
          checkOutput("write_addr", int'(fb_addr_write), expAddrQ.pop_front());
          checkOutput("write_data", int'(fb_cidx_write), expDataQ.pop_front());
        end
        spanWrites++;
        writesSeen++;
      end
      if (done) begin
        if (expErrQ.size() == 0) checkOutput("unexpected_done", 1, 0);
        else begin
          checkOutput("done_err", int'(err), int'(expErrQ.pop_front()));
          checkOutput("span_write_count", spanWrites, expCntQ.pop_front());
        end
        spanWrites = 0;
      end else if (err) begin
        checkOutput("err_without_done", 1, 0);
      end
    end
  end

  // Queue a request into the model and complete one handshake with it.
  task automatic applyStimulus(input int y, input int x0, input int x1, input int c);
    pushSpan(y, x0, x1, c);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_pix);
      if (req_ready) break;
    end
    checkOutput("ready_before_req", int'(req_ready), 1);
    req_y     = 16'(y);
    req_x0    = 16'(x0);
    req_x1    = 16'(x1);
    req_cidx  = 4'(c);
    req_valid = 1'b1;
    @(posedge clk_pix);
    #1;
    hsCyc     = cyc;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for done; cycle numbers are counted from the handshake edge.
  task automatic waitDone(input int hs, input int bound, output int firstRel,
                          output int doneRel, output int nWrites, output int lastAddr);
    firstRel = -1;
    doneRel  = -1;
    nWrites  = 0;
    lastAddr = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_pix);
      if (fb_we) begin
        if (firstRel < 0) firstRel = cyc - hs + 1;
        nWrites++;
        lastAddr = int'(fb_addr_write);
      end
      if (done) begin
        doneRel = cyc - hs + 1;
        break;
      end
    end
  endtask

  task automatic checkReadyAfterDone();
    checkOutput("ready_in_done_cycle", int'(req_ready), 0);
    @(negedge clk_pix);
    checkOutput("ready_after_done", int'(req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int firstRel, doneRel, nWrites, lastAddr, accRel, hsB, weSeen, doneSeen;
    logic pat [7];

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    checkOutput("rst_ready", int'(req_ready), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_we", int'(fb_we), 0);
    checkOutput("rst_addr", int'(fb_addr_write), 0);
    checkOutput("rst_cidx", int'(fb_cidx_write), 0);
    rst = 1'b0;
    @(negedge clk_pix);
    checkOutput("ready_after_rst", int'(req_ready), 1);
    checkEn = 1'b1;

    // Full row 0
    draw_en = 1'b1;
    applyStimulus(0, 0, 159, 0);
    waitDone(hsCyc, 400, firstRel, doneRel, nWrites, lastAddr);
    checkOutput("full_first_we_cycle", firstRel, 3);
    checkOutput("full_done_cycle", doneRel, 163);
    checkOutput("full_writes", nWrites, 160);
    checkOutput("full_last_addr", lastAddr, 159);
    checkReadyAfterDone();

    // Last row, no wrap
    applyStimulus(119, 150, 159, 10);
    waitDone(hsCyc, 100, firstRel, doneRel, nWrites, lastAddr);
    checkOutput("lastrow_done_cycle", doneRel, 13);
    checkOutput("lastrow_writes", nWrites, 10);
    checkOutput("lastrow_last_addr", lastAddr, 19199);
    checkReadyAfterDone();

    // Stalls: draw_en 1,0,0,1,0,1,1 over cycles 2..8
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    draw_en = 1'b0;
    applyStimulus(5, 10, 13, 3);
    @(negedge clk_pix);
    draw_en = 1'b0;
    firstRel = -1;
    nWrites  = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_pix);
      if (fb_we) begin
        if (firstRel < 0) firstRel = cyc - hsCyc + 1;
        nWrites++;
      end
      draw_en = pat[i];
    end
    checkOutput("stall_first_we_cycle", firstRel, 3);
    waitDone(hsCyc, 50, accRel, doneRel, weSeen, lastAddr);
    checkOutput("stall_writes", nWrites + weSeen, 4);
    checkOutput("stall_last_addr", lastAddr, 813);
    checkOutput("stall_done_cycle", doneRel, 10);
    checkReadyAfterDone();
    draw_en = 1'b1;

    // Right-edge clip
    applyStimulus(2, 155, 500, 7);
    waitDone(hsCyc, 50, firstRel, doneRel, nWrites, lastAddr);
    checkOutput("clip_writes", nWrites, 5);
    checkOutput("clip_last_addr", lastAddr, 479);
    checkOutput("clip_done_cycle", doneRel, 8);
    checkReadyAfterDone();

    // Reject: row off screen
    applyStimulus(120, 0, 10, 5);
    waitDone(hsCyc, 50, firstRel, doneRel, nWrites, lastAddr);
    checkOutput("rej_y_done_cycle", doneRel, 3);
    checkOutput("rej_y_err", int'(err), 1);
    checkOutput("rej_y_writes", nWrites, 0);
    checkReadyAfterDone();

    // Reject: x0 beyond x1
    applyStimulus(3, 20, 10, 5);
    waitDone(hsCyc, 50, firstRel, doneRel, nWrites, lastAddr);
    checkOutput("rej_x_done_cycle", doneRel, 3);
    checkOutput("rej_x_err", int'(err), 1);
    checkOutput("rej_x_writes", nWrites, 0);
    checkReadyAfterDone();

    // Reset after the 50th write of a full span
    writesSeen = 0;
    applyStimulus(1, 0, 159, 9);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_pix);
      #1;
      if (writesSeen == 50) break;
    end
    checkOutput("midrst_writes_before", writesSeen, 50);
    rst = 1'b1;
    expAddrQ.delete();
    expDataQ.delete();
    expCntQ.delete();
    expErrQ.delete();
    spanWrites = 0;
    @(negedge clk_pix);
    checkOutput("midrst_we", int'(fb_we), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_addr", int'(fb_addr_write), 0);
    checkOutput("midrst_cidx", int'(fb_cidx_write), 0);
    checkOutput("midrst_ready_in_rst", int'(req_ready), 0);
    rst = 1'b0;
    @(negedge clk_pix);
    checkOutput("midrst_ready_after", int'(req_ready), 1);
    weSeen = 0;
    doneSeen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_pix);
      if (fb_we) weSeen++;
      if (done) doneSeen++;
    end
    checkOutput("midrst_no_more_writes", weSeen, 0);
    checkOutput("midrst_no_done", doneSeen, 0);

    // Two queued requests with req_valid held high
    pushSpan(10, 0, 2, 1);
    pushSpan(11, 5, 6, 2);
    @(negedge clk_pix);
    req_y = 16'd10; req_x0 = 16'd0; req_x1 = 16'd2; req_cidx = 4'd1;
    req_valid = 1'b1;
    @(posedge clk_pix);
    #1;
    hsCyc = cyc;
    req_y = 16'd11; req_x0 = 16'd5; req_x1 = 16'd6; req_cidx = 4'd2;
    doneRel = -1;
    accRel = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_pix);
      if (done) doneRel = cyc - hsCyc + 1;
      if (req_ready) begin
        accRel = cyc - hsCyc + 1;
        break;
      end
    end
    checkOutput("hs_first_done_cycle", doneRel, 6);
    checkOutput("hs_second_accept_cycle", accRel, 7);
    @(posedge clk_pix);
    #1;
    hsB = cyc;
    req_valid = 1'b0;
    waitDone(hsB, 50, firstRel, doneRel, nWrites, lastAddr);
    checkOutput("hs_second_done_cycle", doneRel, 5);
    checkOutput("hs_second_last_addr", lastAddr, 1766);
    checkReadyAfterDone();

    repeat (3) @(negedge clk_pix);
    checkOutput("model_writes_drained", expAddrQ.size(), 0);
    checkOutput("model_spans_drained", expErrQ.size(), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
